// File: rtl/board_reset_pkg.sv
// Shared types and helpers for the board-level reset conditioner.
package board_reset_pkg;

  localparam int RST_COUNT_W = 8;

  typedef enum logic [1:0] {
    CAUSE_NONE   = 2'd0,
    CAUSE_POR    = 2'd1,
    CAUSE_BUTTON = 2'd2,
    CAUSE_SOFT   = 2'd3
  } rst_cause_t;

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_STRETCH = 2'd1,
    ST_RELEASE = 2'd2,
    ST_RUN     = 2'd3
  } rst_state_t;

  // Reset counter holds at all-ones instead of wrapping back to zero.
  function automatic logic [RST_COUNT_W-1:0] sat_inc(input logic [RST_COUNT_W-1:0] v);
    if (v == {RST_COUNT_W{1'b1}}) begin
      return v;
    end else begin
      return v + RST_COUNT_W'(1);
    end
  endfunction

endpackage

// File: rtl/reset_debouncer.sv
// Button synchroniser plus stability filter; rise pulses for one cycle on an accepted press.
module reset_debouncer
  import board_reset_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic rise
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_db;
  logic                   r_rise;
  logic                   w_sync;
  logic                   w_diff;

  assign w_sync = r_sync[SYNC_STAGES-1];
  assign w_diff = w_sync ^ r_db;

  // Any cycle where the synchronised level agrees with the filtered one restarts the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
      r_cnt  <= '0;
      r_db   <= 1'b0;
      r_rise <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], din};
      r_rise <= 1'b0;
      if (!w_diff) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_cnt  <= '0;
        r_db   <= w_sync;
        r_rise <= w_sync;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign dout = r_db;
  assign rise = r_rise;

endmodule

// File: rtl/board_reset_ctrl.sv
// Board reset conditioner: merges power-on, button and host soft resets into
// stretched, staggered active-low domain resets with cause and count reporting.
module board_reset_ctrl
  import board_reset_pkg::*;
#(
  parameter int BTN_ACTIVE_HIGH = 1,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int STRETCH_CYCLES  = 256,
  parameter int NUM_DOMAINS     = 2,
  parameter int STAGGER_CYCLES  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   btn,
  input  logic                   soft_rst_req,
  output logic [NUM_DOMAINS-1:0] rst_n_o,
  output logic                   busy,
  output logic [1:0]             rst_cause,
  output logic [RST_COUNT_W-1:0] rst_count
);

  localparam int LAST_REL = (NUM_DOMAINS - 1) * STAGGER_CYCLES;
  localparam int CNT_MAX  = (STRETCH_CYCLES > LAST_REL) ? STRETCH_CYCLES : LAST_REL;
  localparam int CNT_W    = $clog2(CNT_MAX) + 1;
  localparam logic [CNT_W-1:0] STRETCH_LAST = CNT_W'(STRETCH_CYCLES - 1);

  rst_state_t             r_state, w_state_nxt;
  rst_cause_t             r_cause, w_cause_nxt, w_req_cause;
  logic [CNT_W-1:0]       r_cnt, w_cnt_nxt;
  logic [NUM_DOMAINS-1:0] r_rst_n, w_rst_n_nxt;
  logic [RST_COUNT_W-1:0] r_count, w_count_nxt;
  logic                   r_busy;
  logic                   w_btn, w_db, w_rise, w_req;
  int                     w_elapsed;

  assign w_btn = (BTN_ACTIVE_HIGH != 0) ? btn : ~btn;

  reset_debouncer #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk (clk),
    .rst (rst),
    .din (w_btn),
    .dout(w_db),
    .rise(w_rise)
  );

  assign w_req       = w_rise | soft_rst_req;
  assign w_req_cause = w_rise ? CAUSE_BUTTON : CAUSE_SOFT;
  assign w_elapsed   = int'(r_cnt) + 1;

  // A request outside ASSERT restarts the sequence; otherwise the phase logic advances.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_rst_n_nxt = r_rst_n;
    w_cause_nxt = r_cause;
    w_count_nxt = r_count;
    if (w_req && (r_state != ST_ASSERT)) begin
      w_state_nxt = ST_ASSERT;
      w_cnt_nxt   = '0;
      w_rst_n_nxt = '0;
      w_cause_nxt = w_req_cause;
      w_count_nxt = sat_inc(r_count);
    end else begin
      case (r_state)
        ST_ASSERT: begin
          w_rst_n_nxt = '0;
          if (w_req) begin
            w_cause_nxt = w_req_cause;
          end else begin
            w_cause_nxt = r_cause;
          end
          if (w_db) begin
            w_state_nxt = ST_ASSERT;
          end else begin
            w_state_nxt = ST_STRETCH;
            w_cnt_nxt   = '0;
          end
        end
        ST_STRETCH: begin
          if (r_cnt == STRETCH_LAST) begin
            w_cnt_nxt = '0;
            if (LAST_REL == 0) begin
              w_state_nxt = ST_RUN;
              w_rst_n_nxt = '1;
            end else begin
              w_state_nxt    = ST_RELEASE;
              w_rst_n_nxt    = '0;
              w_rst_n_nxt[0] = 1'b1;
            end
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        ST_RELEASE: begin
          // r_cnt + 1 cycles have passed since domain 0 was let go
          w_cnt_nxt = r_cnt + CNT_W'(1);
          for (int k = 0; k < NUM_DOMAINS; k++) begin
            w_rst_n_nxt[k] = (w_elapsed >= k * STAGGER_CYCLES);
          end
          if (w_elapsed >= LAST_REL) begin
            w_state_nxt = ST_RUN;
          end else begin
            w_state_nxt = ST_RELEASE;
          end
        end
        ST_RUN: begin
          w_rst_n_nxt = '1;
        end
        default: begin
          w_state_nxt = ST_ASSERT;
          w_rst_n_nxt = '0;
        end
      endcase
    end
  end

  // All outputs come straight from flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_ASSERT;
      r_cnt   <= '0;
      r_rst_n <= '0;
      r_busy  <= 1'b1;
      r_cause <= CAUSE_POR;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_rst_n <= w_rst_n_nxt;
      r_busy  <= ~&w_rst_n_nxt;
      r_cause <= w_cause_nxt;
      r_count <= w_count_nxt;
    end
  end

  assign rst_n_o   = r_rst_n;
  assign busy      = r_busy;
  assign rst_cause = r_cause;
  assign rst_count = r_count;

endmodule
